// File: rtl/stage2_fetch_control_if.sv
// Fetch-control bus between stage 1 / decode and the stage-2 fetch controller.
// Signal names match the stage-1 and decode port names they connect to.
interface stage2_fetch_control_if;
    logic [15:0] PCIn;
    logic [15:0] IRIn;
    logic        Stall;
    logic        BranchReq;
    logic [15:0] BranchOffset;
    logic        JumpReq;
    logic [15:0] JumpTarget;
    logic        PCWrite;
    logic        PCAdd;
    logic        PCSource;
    logic [15:0] PCAddFromSE;
    logic [15:0] PCSourceFromValA;
    logic [15:0] PCOut;
    logic [15:0] IROut;
    logic        ValidOut;
    logic [15:0] RedirectCount;

    modport master (
        output PCIn, IRIn, Stall, BranchReq, BranchOffset, JumpReq, JumpTarget,
        input  PCWrite, PCAdd, PCSource, PCAddFromSE, PCSourceFromValA,
               PCOut, IROut, ValidOut, RedirectCount
    );

    modport slave (
        input  PCIn, IRIn, Stall, BranchReq, BranchOffset, JumpReq, JumpTarget,
        output PCWrite, PCAdd, PCSource, PCAddFromSE, PCSourceFromValA,
               PCOut, IROut, ValidOut, RedirectCount
    );
endinterface

// File: rtl/stage2_fetch_control.sv
// Stage-2 fetch control: IF/ID register, branch/jump redirect sequencing
// (RUN -> REDIRECT -> BUBBLE -> RUN) and a saturating redirect counter.
module stage2_fetch_control (
    input  logic                  CLK,
    input  logic                  Reset,
    stage2_fetch_control_if.slave bus
);
    typedef enum logic [1:0] {RUN, REDIRECT, BUBBLE} state_e;

    state_e      state_q, state_d;
    logic        jump_q, jump_d;
    logic [15:0] off_q, off_d;
    logic [15:0] tgt_q, tgt_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        vld_q, vld_d;
    logic [15:0] redirect_cnt_q, redirect_cnt_d;
    logic        accept;
    logic        pc_write, pc_add, pc_source;

    assign accept = (state_q == RUN) && !bus.Stall && (bus.BranchReq || bus.JumpReq);

    always_comb begin
        state_d        = state_q;
        jump_d         = jump_q;
        off_d          = off_q;
        tgt_d          = tgt_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        vld_d          = vld_q;
        redirect_cnt_d = redirect_cnt_q;
        pc_write       = 1'b1;
        pc_add         = 1'b0;
        pc_source      = 1'b0;

        if (bus.Stall) begin
            pc_write = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept) begin
                        // JumpReq wins over BranchReq; only the chosen operand is latched
                        jump_d = bus.JumpReq;
                        if (bus.JumpReq) tgt_d = bus.JumpTarget;
                        else             off_d = bus.BranchOffset;
                        state_d        = REDIRECT;
                        ir_d           = 16'h0000;
                        vld_d          = 1'b0;
                        redirect_cnt_d = (redirect_cnt_q == 16'hFFFF) ? redirect_cnt_q
                                                                     : redirect_cnt_q + 16'd1;
                    end else begin
                        pc_d  = bus.PCIn;
                        ir_d  = bus.IRIn;
                        vld_d = 1'b1;
                    end
                end
                REDIRECT: begin
                    pc_source = jump_q;
                    pc_add    = !jump_q;
                    ir_d      = 16'h0000;
                    vld_d     = 1'b0;
                    state_d   = BUBBLE;
                end
                BUBBLE: begin
                    pc_d    = bus.PCIn;
                    ir_d    = bus.IRIn;
                    vld_d   = 1'b1;
                    state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end

        // Reset forces a plain sequential PC update regardless of stall or redirect
        if (Reset) begin
            pc_write  = 1'b1;
            pc_add    = 1'b0;
            pc_source = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q        <= RUN;
            jump_q         <= 1'b0;
            off_q          <= 16'h0000;
            tgt_q          <= 16'h0000;
            pc_q           <= 16'h0000;
            ir_q           <= 16'h0000;
            vld_q          <= 1'b0;
            redirect_cnt_q <= 16'h0000;
        end else begin
            state_q        <= state_d;
            jump_q         <= jump_d;
            off_q          <= off_d;
            tgt_q          <= tgt_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            vld_q          <= vld_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign bus.PCWrite          = pc_write;
    assign bus.PCAdd            = pc_add;
    assign bus.PCSource         = pc_source;
    assign bus.PCAddFromSE      = off_q;
    assign bus.PCSourceFromValA = tgt_q;
    assign bus.PCOut            = pc_q;
    assign bus.IROut            = ir_q;
    assign bus.ValidOut         = vld_q;
    assign bus.RedirectCount    = redirect_cnt_q;
endmodule

// File: tb/tb_stage2_fetch_control.sv
// Directed scoreboard bench for stage2_fetch_control: the driver queues the
// expected outputs for each cycle, the monitor checks them on the falling edge.
module tb_stage2_fetch_control;
    logic CLK = 1'b0;
    logic Reset;
    stage2_fetch_control_if bus ();

    stage2_fetch_control dut (.CLK(CLK), .Reset(Reset), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        pcw;
        logic        add;
        logic        src;
        logic [15:0] off;
        logic [15:0] tgt;
        logic [15:0] pco;
        logic [15:0] iro;
        logic        v;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Monitor: outputs for a cycle are stable by the falling edge
    always @(negedge CLK) begin
        exp_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{bus.PCWrite, bus.PCAdd, bus.PCSource, bus.PCAddFromSE, bus.PCSourceFromValA,
                  bus.PCOut, bus.IROut, bus.ValidOut, bus.RedirectCount};
            n_vec++;
            if (a !== e) begin
                n_miss++;
                $display("FAIL vec%0d: got pcw=%b add=%b src=%b off=%h tgt=%h pco=%h iro=%h v=%b cnt=%h, want pcw=%b add=%b src=%b off=%h tgt=%h pco=%h iro=%h v=%b cnt=%h",
                         n_vec, a.pcw, a.add, a.src, a.off, a.tgt, a.pco, a.iro, a.v, a.cnt,
                         e.pcw, e.add, e.src, e.off, e.tgt, e.pco, e.iro, e.v, e.cnt);
            end
        end
    end

    // One cycle: drive inputs just after the rising edge, queue what must be seen this cycle
    task automatic cyc(input logic rst, input logic stall, input logic br, input logic [15:0] off,
                       input logic jr, input logic [15:0] tgt, input logic [15:0] pc, input logic [15:0] ir,
                       input logic e_pcw, input logic e_add, input logic e_src, input logic [15:0] e_off,
                       input logic [15:0] e_tgt, input logic [15:0] e_pco, input logic [15:0] e_iro,
                       input logic e_v, input logic [15:0] e_cnt);
        @(posedge CLK);
        #1;
        Reset = rst; bus.Stall = stall; bus.BranchReq = br; bus.BranchOffset = off;
        bus.JumpReq = jr; bus.JumpTarget = tgt; bus.PCIn = pc; bus.IRIn = ir;
        exp_q.push_back('{e_pcw, e_add, e_src, e_off, e_tgt, e_pco, e_iro, e_v, e_cnt});
    endtask

    initial begin
        Reset = 1'b1; bus.Stall = 0; bus.BranchReq = 0; bus.BranchOffset = 0;
        bus.JumpReq = 0; bus.JumpTarget = 0; bus.PCIn = 0; bus.IRIn = 0;

        // Reset state
        cyc(1,0,0,0,0,0,0,0,            1,0,0,16'h0,16'h0,16'h0,16'h0,0,16'h0);
        // Sequential fetch 0..9, IR = PC + 0x100
        for (int i = 0; i < 10; i++) begin
            if (i == 0) cyc(0,0,0,0,0,0,16'(i),16'(i+'h100), 1,0,0,16'h0,16'h0,16'h0,16'h0,0,16'h0);
            else        cyc(0,0,0,0,0,0,16'(i),16'(i+'h100), 1,0,0,16'h0,16'h0,16'(i-1),16'(i-1+'h100),1,16'h0);
        end
        // Branch at PC 20, offset 255; later requests in REDIRECT/BUBBLE are ignored
        cyc(0,0,1,16'd255,0,0,16'd20,16'h5555,          1,0,0,16'h0,16'h0,16'h9,16'h109,1,16'h0);
        cyc(0,0,0,0,1,16'h7777,16'd21,16'h1234,         1,1,0,16'd255,16'h0,16'h9,16'h0,0,16'h1);
        cyc(0,0,1,16'h0011,0,0,16'd276,16'h2222,        1,0,0,16'd255,16'h0,16'h9,16'h0,0,16'h1);
        cyc(0,0,0,0,0,0,16'd277,16'h2223,               1,0,0,16'd255,16'h0,16'd276,16'h2222,1,16'h1);
        // Jump and branch together: jump wins, offset register untouched
        cyc(0,0,1,16'h0010,1,16'd302,16'd300,16'h3333,  1,0,0,16'd255,16'h0,16'd277,16'h2223,1,16'h1);
        cyc(0,0,0,0,0,0,16'd301,16'h3334,               1,0,1,16'd255,16'd302,16'd277,16'h0,0,16'h2);
        cyc(0,0,0,0,0,0,16'd302,16'h4444,               1,0,0,16'd255,16'd302,16'd277,16'h0,0,16'h2);
        cyc(0,0,0,0,0,0,16'd303,16'h4445,               1,0,0,16'd255,16'd302,16'd302,16'h4444,1,16'h2);
        // Stall 3 cycles with a pending branch, then accept; stall also inside REDIRECT
        for (int i = 0; i < 3; i++)
            cyc(0,1,1,16'h0040,0,0,16'd304,16'h4446,    0,0,0,16'd255,16'd302,16'd303,16'h4445,1,16'h2);
        cyc(0,0,1,16'h0040,0,0,16'd304,16'h4446,        1,0,0,16'd255,16'd302,16'd303,16'h4445,1,16'h2);
        cyc(0,1,0,0,0,0,16'd305,16'h4447,               0,0,0,16'h0040,16'd302,16'd303,16'h0,0,16'h3);
        cyc(0,0,0,0,0,0,16'd305,16'h4447,               1,1,0,16'h0040,16'd302,16'd303,16'h0,0,16'h3);
        cyc(0,0,0,0,0,0,16'h0044,16'h5000,              1,0,0,16'h0040,16'd302,16'd303,16'h0,0,16'h3);
        cyc(0,0,0,0,0,0,16'h0045,16'h5001,              1,0,0,16'h0040,16'd302,16'h0044,16'h5000,1,16'h3);
        // Jump, then reset (with stall) while in REDIRECT
        cyc(0,0,0,0,1,16'h0ABC,16'h0046,16'h5002,       1,0,0,16'h0040,16'd302,16'h0045,16'h5001,1,16'h3);
        cyc(1,1,0,0,0,0,16'h0047,16'h5003,              1,0,0,16'h0040,16'h0ABC,16'h0045,16'h0,0,16'h4);
        cyc(0,0,0,0,0,0,16'h0000,16'h0100,              1,0,0,16'h0,16'h0,16'h0,16'h0,0,16'h0);
        cyc(0,0,0,0,0,0,16'h0001,16'h0101,              1,0,0,16'h0,16'h0,16'h0,16'h0100,1,16'h0);
        // Saturation: preload count to 0xFFFE under stall, then two redirects
        cyc(0,1,0,0,0,0,16'h0002,16'h0102,              0,0,0,16'h0,16'h0,16'h1,16'h0101,1,16'hFFFE);
        force dut.redirect_cnt_q = 16'hFFFE;
        cyc(0,0,1,16'h0007,0,0,16'h0002,16'h0102,       1,0,0,16'h0,16'h0,16'h1,16'h0101,1,16'hFFFE);
        release dut.redirect_cnt_q;
        cyc(0,0,0,0,0,0,16'h0003,16'h0103,              1,1,0,16'h0007,16'h0,16'h1,16'h0,0,16'hFFFF);
        cyc(0,0,0,0,0,0,16'h0008,16'h0800,              1,0,0,16'h0007,16'h0,16'h1,16'h0,0,16'hFFFF);
        cyc(0,0,0,0,1,16'h0020,16'h0009,16'h0801,       1,0,0,16'h0007,16'h0,16'h8,16'h0800,1,16'hFFFF);
        cyc(0,0,0,0,0,0,16'h000A,16'h0802,              1,0,1,16'h0007,16'h0020,16'h8,16'h0,0,16'hFFFF);
        cyc(0,0,0,0,0,0,16'h0020,16'h0900,              1,0,0,16'h0007,16'h0020,16'h8,16'h0,0,16'hFFFF);
        cyc(0,0,0,0,0,0,16'h0021,16'h0901,              1,0,0,16'h0007,16'h0020,16'h0020,16'h0900,1,16'hFFFF);

        for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(posedge CLK);
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/stage2_fetch_control.md
STAGE2_FETCH_CONTROL -- requirements
Module: stage2_fetch_control

Interface
REQ-001 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port Reset, input, 1 bit: reset, synchronous and active-high.
REQ-003 The module SHALL have port PCIn, input, 16 bits: the current PC from the stage-1 PC incrementer.
REQ-004 The module SHALL have port IRIn, input, 16 bits: the instruction word fetched at PCIn.
REQ-005 The module SHALL have port Stall, input, 1 bit: a hazard hold request from decode.
REQ-006 The module SHALL have port BranchReq, input, 1 bit: a taken-branch request.
REQ-007 The module SHALL have port BranchOffset, input, 16 bits: the signed PC offset for a branch.
REQ-008 The module SHALL have port JumpReq, input, 1 bit: a jump request.
REQ-009 The module SHALL have port JumpTarget, input, 16 bits: the absolute jump address (ValA).
REQ-010 The module SHALL have port PCWrite, output, 1 bit: the PC update enable to stage 1.
REQ-011 The module SHALL have port PCAdd, output, 1 bit: the stage-1 select for PC + offset.
REQ-012 The module SHALL have port PCSource, output, 1 bit: the stage-1 select for the absolute target.
REQ-013 The module SHALL have port PCAddFromSE, output, 16 bits: the offset driven to stage 1.
REQ-014 The module SHALL have port PCSourceFromValA, output, 16 bits: the target driven to stage 1.
REQ-015 The module SHALL have port PCOut, output, 16 bits: the IF/ID-registered PC.
REQ-016 The module SHALL have port IROut, output, 16 bits: the IF/ID-registered instruction.
REQ-017 The module SHALL have port ValidOut, output, 1 bit: IROut holds a real, non-squashed instruction.
REQ-018 The module SHALL have port RedirectCount, output, 16 bits: a saturating count of accepted redirects.

Function
REQ-019 The FSM SHALL have exactly three states: RUN, REDIRECT and BUBBLE.
REQ-020 In RUN with Stall=0 and no request, the outputs SHALL be PCWrite=1 and PCAdd=PCSource=0, and IF/ID SHALL load PCIn/IRIn with ValidOut=1 on the next edge.
REQ-021 When Stall=1 in any state, PCWrite SHALL be 0, IF/ID, state and RedirectCount SHALL hold, and BranchReq/JumpReq SHALL be ignored; decode holds requests until Stall=0.
REQ-022 In RUN with Stall=0 and JumpReq=1, the block SHALL latch JumpTarget into PCSourceFromValA and enter REDIRECT with the JUMP kind; JumpReq SHALL take priority over BranchReq.
REQ-023 In RUN with Stall=0, BranchReq=1 and JumpReq=0, the block SHALL latch BranchOffset into PCAddFromSE and enter REDIRECT with the BRANCH kind.
REQ-024 On the accepting edge of a redirect request, IF/ID SHALL be flushed: IROut=0x0000 (NOP), PCOut held, ValidOut=0.
REQ-025 In REDIRECT, for exactly one cycle, the outputs SHALL be PCWrite=1 with PCSource=1 for JUMP or PCAdd=1 for BRANCH; IF/ID SHALL stay flushed; the next state SHALL be BUBBLE.
REQ-026 In BUBBLE, for one cycle, the outputs SHALL be PCWrite=1 and PCAdd=PCSource=0, IF/ID SHALL load PCIn/IRIn with ValidOut=1, and the next state SHALL be RUN.
REQ-027 Requests arriving in REDIRECT or BUBBLE SHALL be ignored.
REQ-028 PCAddFromSE and PCSourceFromValA SHALL hold their last latched values outside redirects.
REQ-029 All arithmetic SHALL be done in stage 1; this block SHALL perform no addition on PC values.
REQ-030 RedirectCount SHALL increment by 1 on each accepted request and SHALL saturate at 0xFFFF with no wrap.
REQ-031 PCAdd and PCSource SHALL never both be 1.

Reset
REQ-032 When Reset=1 at a rising edge: state=RUN, PCOut=0, IROut=0, ValidOut=0, PCAddFromSE=0, PCSourceFromValA=0, RedirectCount=0.
REQ-033 During Reset=1, PCWrite SHALL be 1 and PCAdd=PCSource=0.
REQ-034 Reset SHALL override a redirect in progress; the first cycle after reset SHALL be RUN.
REQ-035 Reset SHALL take priority over Stall.

Verification
REQ-036 Sequential scenario: reset, then PCIn=0..9 with IRIn=PCIn+0x100 -> each next edge PCOut=PCIn, IROut=PCIn+0x100, ValidOut=1, PCWrite=1.
REQ-037 Branch scenario: PCIn=20, BranchReq=1, BranchOffset=255 -> next cycle PCAdd=1, PCAddFromSE=255, ValidOut=0, IROut=0; then one BUBBLE; then RUN; RedirectCount=1.
REQ-038 Jump-priority scenario: BranchReq=1 and JumpReq=1 with JumpTarget=302 -> PCSource=1, PCSourceFromValA=302, PCAdd=0.
REQ-039 Stall scenario: Stall=1 for 3 cycles with BranchReq=1 -> PCWrite=0, IF/ID unchanged, count unchanged; on Stall=0 the branch is accepted.
REQ-040 Reset-in-redirect scenario: Reset=1 in REDIRECT -> next cycle RUN, ValidOut=0, RedirectCount=0; saturation scenario: preload count to 0xFFFE, two redirects -> RedirectCount=0xFFFF.
